// File: rtl/data_memory_block.sv
// Data-memory stage of the 16-bit MIPS datapath: word-addressed RAM accessed with the
// EX result as address, plus a registered select between load data and EX pass-through.
module data_memory_block #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ans_ex,
  input  logic [DATA_W-1:0] DM_data,
  input  logic              mem_rw_ex,
  input  logic              mem_en_ex,
  input  logic              mem_mux_sel_dm,
  output logic [DATA_W-1:0] ans_dm
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] ans_dm_q;
  logic [DATA_W-1:0] ans_dm_d;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] addr;
  logic              wr_en;

  // Upper address bits are dropped on purpose, so addresses alias modulo DEPTH.
  assign addr  = ans_ex[ADDR_W-1:0];
  assign wr_en = mem_en_ex & mem_rw_ex;

  // Read sees the contents before any write at this edge.
  assign rd_data  = mem_en_ex ? mem_q[addr] : '0;
  assign ans_dm_d = mem_mux_sel_dm ? rd_data : ans_ex;

  // Per-word registers: the whole array must clear asynchronously on reset.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_word
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          mem_q[gi] <= '0;
        end else if (wr_en && (addr == ADDR_W'(gi))) begin
          mem_q[gi] <= DM_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ans_dm_q <= '0;
    end else begin
      ans_dm_q <= ans_dm_d;
    end
  end

  assign ans_dm = ans_dm_q;

endmodule

// File: tb/tb_data_memory_block.sv
// Randomised scoreboard bench for data_memory_block: stimulus pushes expected ans_dm
// values computed from an array model, a monitor pops and compares after each edge.
module tb_data_memory_block;

  logic        clk;
  logic        reset;
  logic [15:0] ans_ex;
  logic [15:0] DM_data;
  logic        mem_rw_ex;
  logic        mem_en_ex;
  logic        mem_mux_sel_dm;
  logic [15:0] ans_dm;

  data_memory_block #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .ans_ex         (ans_ex),
    .DM_data        (DM_data),
    .mem_rw_ex      (mem_rw_ex),
    .mem_en_ex      (mem_en_ex),
    .mem_mux_sel_dm (mem_mux_sel_dm),
    .ans_dm         (ans_dm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] model_mem [256];
  logic [15:0] exp_q [$];
  string       name_q [$];
  int          compared   = 0;
  int          mismatched = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: ans_dm=%h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: ans_dm=%h", name, act);
    end
  endtask

  // Predict what the coming edge registers, given the inputs currently driven.
  task automatic model_step(input string name);
    logic [15:0] rd;
    int a;
    a  = int'(ans_ex) % 256;
    rd = mem_en_ex ? model_mem[a] : 16'h0000;
    exp_q.push_back(mem_mux_sel_dm ? rd : ans_ex);
    name_q.push_back(name);
    if (mem_en_ex && mem_rw_ex) model_mem[a] = DM_data;
  endtask

  task automatic do_cycle(input string name, input logic en, input logic rw, input logic sel,
                          input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    mem_en_ex = en; mem_rw_ex = rw; mem_mux_sel_dm = sel; ans_ex = a; DM_data = d;
    model_step(name);
  endtask

  // Reset pulse placed between edges; output must clear with no clock edge.
  task automatic do_reset(input string name);
    @(negedge clk);
    ans_ex = 16'h0003; DM_data = 16'hFFFF; mem_en_ex = 1'b0; mem_rw_ex = 1'b0; mem_mux_sel_dm = 1'b0;
    reset = 1'b1;
    #1;
    check(name, ans_dm, 16'h0000);
    for (int i = 0; i < 256; i++) model_mem[i] = 16'h0000;
    #2;
    reset = 1'b0;
    model_step({name, "_first_edge"});
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (!reset && exp_q.size() > 0) check(name_q.pop_front(), ans_dm, exp_q.pop_front());
    end
  end

  initial begin : stimulus
    logic [15:0] a;
    reset = 1'b1; ans_ex = '0; DM_data = '0; mem_rw_ex = 1'b0; mem_en_ex = 1'b0; mem_mux_sel_dm = 1'b0;
    for (int i = 0; i < 256; i++) model_mem[i] = 16'h0000;
    #1;
    check("reset_at_t0", ans_dm, 16'h0000);

    do_reset("reset_clear");
    do_cycle("read_after_reset", 1'b1, 1'b0, 1'b1, 16'h0003, 16'h0000);
    do_cycle("store_old_data",   1'b1, 1'b1, 1'b1, 16'h0003, 16'hFFFF);
    do_cycle("load_new_data",    1'b1, 1'b0, 1'b1, 16'h0003, 16'h0000);
    do_cycle("pass_through",     1'b0, 1'b0, 1'b0, 16'h1234, 16'h5555);
    do_cycle("mem3_unchanged",   1'b1, 1'b0, 1'b1, 16'h0003, 16'h0000);
    do_cycle("disabled_read",    1'b0, 1'b0, 1'b1, 16'h0003, 16'h0000);
    do_cycle("store_sel0",       1'b1, 1'b1, 1'b0, 16'h0105, 16'hA5A5);
    do_cycle("alias_read",       1'b1, 1'b0, 1'b1, 16'h0005, 16'h0000);
    do_cycle("store_mid",        1'b1, 1'b1, 1'b0, 16'h0003, 16'hFFFF);
    do_cycle("pass_before_rst",  1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000);
    do_reset("reset_mid_op");
    do_cycle("read3_after_rst",  1'b1, 1'b0, 1'b1, 16'h0003, 16'h0000);
    do_cycle("read5_after_rst",  1'b1, 1'b0, 1'b1, 16'h0005, 16'h0000);

    for (int n = 0; n < 400; n++) begin
      a = 16'($urandom);
      if ($urandom_range(0, 1) == 0) a = a & 16'hF807;
      do_cycle("random", 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 3) != 0),
               a, 16'($urandom));
    end

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d expected results left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
